// File: rtl/pipeline_hazard_ctrl_if.sv
// Per-stage stall/flush control bundle between the hazard controller (master) and the datapath (slave).
// Optional perf counters exist only when PIPE_HAZARD_PERF_EN is defined.
interface pipeline_hazard_ctrl_if;
    logic [4:0]  IF_ID_rs;
    logic [4:0]  IF_ID_rt;
    logic        IF_ID_UsesRt;
    logic        ID_EX_MemRead;
    logic [4:0]  ID_EX_rt;
    logic        ID_Jump;
    logic        EX_BranchTaken;
    logic        EX_MEM_MemOp;
    logic        dmem_ready;
    logic        dmem_req;
    logic        mem_error;
    logic        PC_Stall;
    logic        IF_ID_Stall;
    logic        IF_ID_Flush;
    logic        ID_EX_Stall;
    logic        ID_EX_Flush;
    logic        EX_MEM_Stall;
    logic        EX_MEM_Flush;
    logic        MEM_WB_Stall;
    logic        MEM_WB_Flush;
`ifdef PIPE_HAZARD_PERF_EN
    logic [31:0] stall_cycles;
    logic [31:0] flush_events;
`endif

    modport master (
`ifdef PIPE_HAZARD_PERF_EN
        output stall_cycles,
        output flush_events,
`endif
        input  IF_ID_rs,
        input  IF_ID_rt,
        input  IF_ID_UsesRt,
        input  ID_EX_MemRead,
        input  ID_EX_rt,
        input  ID_Jump,
        input  EX_BranchTaken,
        input  EX_MEM_MemOp,
        input  dmem_ready,
        output dmem_req,
        output mem_error,
        output PC_Stall,
        output IF_ID_Stall,
        output IF_ID_Flush,
        output ID_EX_Stall,
        output ID_EX_Flush,
        output EX_MEM_Stall,
        output EX_MEM_Flush,
        output MEM_WB_Stall,
        output MEM_WB_Flush
    );

    modport slave (
`ifdef PIPE_HAZARD_PERF_EN
        input  stall_cycles,
        input  flush_events,
`endif
        output IF_ID_rs,
        output IF_ID_rt,
        output IF_ID_UsesRt,
        output ID_EX_MemRead,
        output ID_EX_rt,
        output ID_Jump,
        output EX_BranchTaken,
        output EX_MEM_MemOp,
        output dmem_ready,
        input  dmem_req,
        input  mem_error,
        input  PC_Stall,
        input  IF_ID_Stall,
        input  IF_ID_Flush,
        input  ID_EX_Stall,
        input  ID_EX_Flush,
        input  EX_MEM_Stall,
        input  EX_MEM_Flush,
        input  MEM_WB_Stall,
        input  MEM_WB_Flush
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: load-use, branch/jump and multi-cycle data-memory stalls/flushes.
// Define PIPE_HAZARD_PERF_EN to add the stall_cycles / flush_events counters.
module pipeline_hazard_ctrl #(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    pipeline_hazard_ctrl_if.master hz
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] wait_cnt_q;
    logic [CNT_W-1:0] wait_cnt_d;
    logic             mem_error_q;
    logic             mem_error_d;

    logic memstall_s;
    logic dmem_req_s;
    logic load_use_s;
    logic pc_stall_s;
    logic if_id_stall_s;
    logic if_id_flush_s;
    logic id_ex_stall_s;
    logic id_ex_flush_s;
    logic ex_mem_stall_s;
    logic mem_wb_flush_s;

    // Memory FSM state, wait counter and sticky timeout flag
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            wait_cnt_q  <= {CNT_W{1'b0}};
            mem_error_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            mem_error_q <= mem_error_d;
        end
    end

    // Memory FSM next state; memstall drops on the completing or abandoning cycle
    always_comb begin
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        mem_error_d = mem_error_q;
        memstall_s  = 1'b0;
        dmem_req_s  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                dmem_req_s = hz.EX_MEM_MemOp;
                if (hz.EX_MEM_MemOp && !hz.dmem_ready) begin
                    memstall_s = 1'b1;
                    state_d    = ST_WAIT;
                    wait_cnt_d = CNT_W'(1);
                end else begin
                    state_d    = ST_IDLE;
                end
            end
            ST_WAIT: begin
                dmem_req_s = 1'b1;
                if (hz.dmem_ready) begin
                    state_d    = ST_IDLE;
                    wait_cnt_d = {CNT_W{1'b0}};
                end else if (wait_cnt_q == TIMEOUT_C) begin
                    state_d     = ST_IDLE;
                    wait_cnt_d  = {CNT_W{1'b0}};
                    mem_error_d = 1'b1;
                end else begin
                    memstall_s = 1'b1;
                    wait_cnt_d = wait_cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d    = ST_IDLE;
                wait_cnt_d = {CNT_W{1'b0}};
            end
        endcase
    end

    assign load_use_s = hz.ID_EX_MemRead && (hz.ID_EX_rt != 5'd0) &&
                        ((hz.ID_EX_rt == hz.IF_ID_rs) ||
                         (hz.IF_ID_UsesRt && (hz.ID_EX_rt == hz.IF_ID_rt)));

    // Prioritised stall/flush resolution; everything is forced low while reset is held
    always_comb begin
        pc_stall_s     = 1'b0;
        if_id_stall_s  = 1'b0;
        if_id_flush_s  = 1'b0;
        id_ex_stall_s  = 1'b0;
        id_ex_flush_s  = 1'b0;
        ex_mem_stall_s = 1'b0;
        mem_wb_flush_s = 1'b0;
        if (reset) begin
            pc_stall_s = 1'b0;
        end else if (memstall_s) begin
            pc_stall_s     = 1'b1;
            if_id_stall_s  = 1'b1;
            id_ex_stall_s  = 1'b1;
            ex_mem_stall_s = 1'b1;
            mem_wb_flush_s = 1'b1;
        end else if (hz.EX_BranchTaken) begin
            if_id_flush_s = 1'b1;
            id_ex_flush_s = 1'b1;
        end else if (load_use_s) begin
            pc_stall_s    = 1'b1;
            if_id_stall_s = 1'b1;
            id_ex_flush_s = 1'b1;
        end else if (hz.ID_Jump) begin
            if_id_flush_s = 1'b1;
        end else begin
            pc_stall_s = 1'b0;
        end
    end

    assign hz.dmem_req     = dmem_req_s & ~reset;
    assign hz.mem_error    = mem_error_q;
    assign hz.PC_Stall     = pc_stall_s;
    assign hz.IF_ID_Stall  = if_id_stall_s;
    assign hz.IF_ID_Flush  = if_id_flush_s;
    assign hz.ID_EX_Stall  = id_ex_stall_s;
    assign hz.ID_EX_Flush  = id_ex_flush_s;
    assign hz.EX_MEM_Stall = ex_mem_stall_s;
    assign hz.EX_MEM_Flush = 1'b0;
    assign hz.MEM_WB_Stall = 1'b0;
    assign hz.MEM_WB_Flush = mem_wb_flush_s;

`ifdef PIPE_HAZARD_PERF_EN
    logic [31:0] stall_cycles_q;
    logic [31:0] stall_cycles_d;
    logic [31:0] flush_events_q;
    logic [31:0] flush_events_d;

    // PC_Stall is high exactly when a memstall or load-use stall is in effect
    always_comb begin
        stall_cycles_d = stall_cycles_q + (pc_stall_s ? 32'd1 : 32'd0);
        flush_events_d = flush_events_q + (if_id_flush_s ? 32'd1 : 32'd0);
    end

    // Free-running perf counters, wrapping modulo 2^32
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cycles_q <= 32'd0;
            flush_events_q <= 32'd0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
            flush_events_q <= flush_events_d;
        end
    end

    assign hz.stall_cycles = stall_cycles_q;
    assign hz.flush_events = flush_events_q;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: directed scenarios plus randomized traffic vs a behavioural model.
module tb_pipeline_hazard_ctrl;
    localparam int TO = 4;

    // Output vector order: dmem_req, mem_error, PC_S, IF_ID_S, IF_ID_F, ID_EX_S, ID_EX_F, EX_MEM_S, EX_MEM_F, MEM_WB_S, MEM_WB_F
    localparam logic [10:0] B_REQ = 11'h400;
    localparam logic [10:0] B_ERR = 11'h200;
    localparam logic [10:0] B_PCS = 11'h100;
    localparam logic [10:0] B_IFS = 11'h080;
    localparam logic [10:0] B_IFF = 11'h040;
    localparam logic [10:0] B_IDS = 11'h020;
    localparam logic [10:0] B_IDF = 11'h010;
    localparam logic [10:0] B_EXS = 11'h008;
    localparam logic [10:0] B_MWF = 11'h001;
    localparam logic [10:0] V_MEM = B_REQ | B_PCS | B_IFS | B_IDS | B_EXS | B_MWF;
    localparam logic [10:0] V_LU  = B_PCS | B_IFS | B_IDF;
    localparam logic [10:0] V_BR  = B_IFF | B_IDF;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    bit   m_waiting;
    int   m_k;
    bit   m_err;
    logic [31:0] m_stall;
    logic [31:0] m_flush;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl_if hz_if();

    pipeline_hazard_ctrl #(.TIMEOUT(TO), .CNT_W(8)) dut (
        .clk   (clk),
        .reset (reset),
        .hz    (hz_if)
    );

    function automatic logic [10:0] obs_vec();
        return {hz_if.dmem_req, hz_if.mem_error, hz_if.PC_Stall, hz_if.IF_ID_Stall, hz_if.IF_ID_Flush,
                hz_if.ID_EX_Stall, hz_if.ID_EX_Flush, hz_if.EX_MEM_Stall, hz_if.EX_MEM_Flush,
                hz_if.MEM_WB_Stall, hz_if.MEM_WB_Flush};
    endfunction

    // Reference: an access stalls until ready, giving up after TO stall cycles
    function automatic logic [10:0] model_vec();
        logic [10:0] v = 11'd0;
        bit active, ms, lu;
        active = m_waiting || hz_if.EX_MEM_MemOp;
        ms = active && !hz_if.dmem_ready && (m_k < TO);
        lu = hz_if.ID_EX_MemRead && (hz_if.ID_EX_rt != 5'd0) &&
             (hz_if.ID_EX_rt == hz_if.IF_ID_rs || (hz_if.IF_ID_UsesRt && hz_if.ID_EX_rt == hz_if.IF_ID_rt));
        if (active) v = v | B_REQ;
        if (m_err)  v = v | B_ERR;
        if (ms)                        v = v | V_MEM;
        else if (hz_if.EX_BranchTaken) v = v | V_BR;
        else if (lu)                   v = v | V_LU;
        else if (hz_if.ID_Jump)        v = v | B_IFF;
        return v;
    endfunction

    task automatic model_update();
        logic [10:0] v;
        v = model_vec();
        m_stall = m_stall + {31'd0, v[8]};
        m_flush = m_flush + {31'd0, v[6]};
        if (m_waiting || hz_if.EX_MEM_MemOp) begin
            if (hz_if.dmem_ready) begin
                m_waiting = 1'b0; m_k = 0;
            end else if (m_k < TO) begin
                m_waiting = 1'b1; m_k = m_k + 1;
            end else begin
                m_waiting = 1'b0; m_k = 0; m_err = 1'b1;
            end
        end
    endtask

    task automatic model_reset();
        m_waiting = 1'b0; m_k = 0; m_err = 1'b0;
        m_stall = 32'd0; m_flush = 32'd0;
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic set_in(input logic [4:0] rs, input logic [4:0] rt, input logic uses, input logic mr,
                          input logic [4:0] exrt, input logic jmp, input logic br, input logic mop,
                          input logic rdy);
        hz_if.IF_ID_rs = rs;       hz_if.IF_ID_rt = rt;       hz_if.IF_ID_UsesRt = uses;
        hz_if.ID_EX_MemRead = mr;  hz_if.ID_EX_rt = exrt;     hz_if.ID_Jump = jmp;
        hz_if.EX_BranchTaken = br; hz_if.EX_MEM_MemOp = mop;  hz_if.dmem_ready = rdy;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        model_reset();
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        logic [10:0] act;
        reset = 1'b1;
        set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        model_reset();
        #1;
        act = obs_vec();
        checks++;
        if (act !== 11'd0) begin errors++; $display("FAIL reset_during got %b want %b", act, 11'd0); end
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        act = obs_vec();
        checks++;
        if (act !== 11'd0) begin errors++; $display("FAIL reset_after got %b want %b", act, 11'd0); end
        @(negedge clk);
    endtask

    task automatic test_load_use();
        logic [10:0] act, exp;
        for (int i = 0; i < 7; i++) begin
            case (i)
                0: begin set_in(5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0); exp = V_LU;  end
                1: begin set_in(5'd5, 5'd0, 1'b0, 1'b0, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0); exp = 11'd0; end
                2: begin set_in(5'd3, 5'd5, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0); exp = V_LU;  end
                3: begin set_in(5'd3, 5'd5, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0); exp = 11'd0; end
                4: begin set_in(5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0); exp = 11'd0; end
                5: begin set_in(5'd7, 5'd0, 1'b0, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0); exp = V_LU;  end
                default: begin set_in(5'd7, 5'd0, 1'b0, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0); exp = B_IFF; end
            endcase
            #1;
            act = obs_vec();
            checks++;
            if (act !== exp) begin errors++; $display("FAIL load_use step %0d got %b want %b", i, act, exp); end
            tick();
        end
    endtask

    task automatic test_branch();
        logic [10:0] act, exp;
        for (int i = 0; i < 3; i++) begin
            case (i)
                0: set_in(5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b1, 1'b0, 1'b0);
                1: set_in(5'd1, 5'd2, 1'b0, 1'b0, 5'd3, 1'b0, 1'b1, 1'b0, 1'b0);
                default: set_in(5'd1, 5'd2, 1'b0, 1'b0, 5'd3, 1'b1, 1'b1, 1'b0, 1'b0);
            endcase
            exp = V_BR;
            #1;
            act = obs_vec();
            checks++;
            if (act !== exp) begin errors++; $display("FAIL branch step %0d got %b want %b", i, act, exp); end
            tick();
        end
    endtask

    task automatic test_mem_wait();
        logic [10:0] act, exp;
        for (int i = 0; i < 7; i++) begin
            case (i)
                0, 2: begin set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0); exp = V_MEM; end
                1: begin set_in(5'd4, 5'd0, 1'b0, 1'b1, 5'd4, 1'b1, 1'b1, 1'b1, 1'b0); exp = V_MEM; end
                3, 5: begin set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1); exp = B_REQ; end
                default: begin set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0); exp = 11'd0; end
            endcase
            #1;
            act = obs_vec();
            checks++;
            if (act !== exp) begin errors++; $display("FAIL mem_wait step %0d got %b want %b", i, act, exp); end
            tick();
        end
    endtask

    task automatic test_timeout();
        logic [10:0] act, exp;
        for (int i = 0; i < 7; i++) begin
            if (i < 5) set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
            else if (i == 5) set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
            else set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
            if (i < 4) exp = V_MEM;
            else if (i == 4) exp = B_REQ;
            else if (i == 5) exp = B_ERR;
            else exp = B_ERR | B_IFF;
            #1;
            act = obs_vec();
            checks++;
            if (act !== exp) begin errors++; $display("FAIL timeout step %0d got %b want %b", i, act, exp); end
            tick();
        end
    endtask

    task automatic test_reset_in_wait();
        logic [10:0] act;
        for (int i = 0; i < 2; i++) begin
            set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
            #1;
            act = obs_vec();
            checks++;
            if (act !== (V_MEM | B_ERR)) begin
                errors++; $display("FAIL rst_wait_pre step %0d got %b want %b", i, act, V_MEM | B_ERR);
            end
            tick();
        end
        #2;
        reset = 1'b1;
        #1;
        act = obs_vec();
        checks++;
        if (act !== 11'd0) begin errors++; $display("FAIL rst_wait_async got %b want %b", act, 11'd0); end
        @(posedge clk);
        @(negedge clk);
        model_reset();
        reset = 1'b0;
        set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        act = obs_vec();
        checks++;
        if (act !== 11'd0) begin errors++; $display("FAIL rst_wait_idle got %b want %b", act, 11'd0); end
        tick();
    endtask

    task automatic test_random();
        logic [10:0] act, exp;
        apply_reset();
        for (int i = 0; i < 400; i++) begin
            set_in(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0),
                   ($urandom_range(0, 4) == 0), ($urandom_range(0, 9) < 4), ($urandom_range(0, 9) < 3));
            #1;
            act = obs_vec();
            exp = model_vec();
            checks++;
            if (act !== exp) begin errors++; $display("FAIL random cycle %0d got %b want %b", i, act, exp); end
`ifdef PIPE_HAZARD_PERF_EN
            checks++;
            if (hz_if.stall_cycles !== m_stall || hz_if.flush_events !== m_flush) begin
                errors++;
                $display("FAIL random_perf cycle %0d got %0d/%0d want %0d/%0d", i,
                         hz_if.stall_cycles, hz_if.flush_events, m_stall, m_flush);
            end
`endif
            tick();
        end
    endtask

`ifdef PIPE_HAZARD_PERF_EN
    task automatic test_perf();
        apply_reset();
        checks++;
        if (hz_if.stall_cycles !== 32'd0 || hz_if.flush_events !== 32'd0) begin
            errors++; $display("FAIL perf_reset got %0d/%0d want 0/0", hz_if.stall_cycles, hz_if.flush_events);
        end
        for (int i = 0; i < 6; i++) begin
            if (i < 3) set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
            else if (i == 3) set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
            else if (i == 4) set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
            else set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
            tick();
        end
        #1;
        checks++;
        if (hz_if.stall_cycles !== 32'd3 || hz_if.flush_events !== 32'd1) begin
            errors++; $display("FAIL perf_count got %0d/%0d want 3/1", hz_if.stall_cycles, hz_if.flush_events);
        end
    endtask
`endif

    initial begin
        reset = 1'b1;
        set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        model_reset();
        @(negedge clk);
        test_reset();
        test_load_use();
        test_branch();
        test_mem_wait();
        test_timeout();
        test_reset_in_wait();
        test_random();
`ifdef PIPE_HAZARD_PERF_EN
        test_perf();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
